// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus width defaults (common with user_proj),
// the initiator FSM state type and response status codes.
package wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;

    // rsp_err_o encoding
    localparam logic WB_RSP_OK          = 1'b0;
    localparam logic WB_RSP_ERR_TIMEOUT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_init_state_t;

endpackage

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer master: one bus cycle per command, with a
// bounded ack wait that aborts and reports an error on timeout.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_W-1:0]     cmd_adr_i,
    input  logic [DATA_W-1:0]     cmd_dat_i,
    input  logic [DATA_W/8-1:0]   cmd_sel_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_dat_o,
    output logic                  rsp_err_o,

    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    input  logic                  wbm_ack_i,
    input  logic [DATA_W-1:0]     wbm_dat_i,

    output logic [CNT_W-1:0]      xfer_cnt_o
);

    localparam int                SEL_W     = DATA_W / 8;
    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    wb_init_state_t      r_state;
    logic                r_cyc;
    logic                r_we;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic [SEL_W-1:0]    r_sel;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_dat;
    logic                r_rsp_err;
    logic [CNT_W-1:0]    r_xfer_cnt;

    logic                w_accept;
    logic [CNT_W-1:0]    w_xfer_cnt_inc;

    // Gated by reset so no command is taken while the block is held in reset.
    assign cmd_ready_o    = (r_state == IDLE) && !reset;
    assign w_accept       = cmd_valid_i && cmd_ready_o;
    assign w_xfer_cnt_inc = (r_xfer_cnt == CNT_MAX) ? r_xfer_cnt : r_xfer_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_wait      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_xfer_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we    <= cmd_we_i;
                        r_adr   <= cmd_adr_i;
                        r_dat   <= cmd_dat_i;
                        r_sel   <= cmd_sel_i;
                        r_wait  <= '0;
                        r_cyc   <= 1'b1;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    // Ack is checked first so a late ack on the final wait cycle still completes.
                    if (wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
                        r_rsp_err   <= WB_RSP_OK;
                        r_xfer_cnt  <= w_xfer_cnt_inc;
                        r_state     <= RESP;
                    end else if (r_wait == WAIT_LAST) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= WB_RSP_ERR_TIMEOUT;
                        r_xfer_cnt  <= w_xfer_cnt_inc;
                        r_state     <= RESP;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_cyc       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = r_sel;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign xfer_cnt_o  = r_xfer_cnt;

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: transaction-level timing model plus a
// memory-backed slave stand-in, checked every cycle, with directed literal pins.
`timescale 1ns/1ps
module tb_wb_initiator;
    import wb_pkg::*;

    localparam int AW      = WB_ADDR_W;
    localparam int DW      = WB_DATA_W;
    localparam int SW      = DW / 8;
    localparam int TO      = 16;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int NTX     = 64;
    localparam int BIG     = 1000000000;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int            lat;    // bus cycle (1-based) in which the slave acks; > TO means never
        int            rdly;   // extra cycles the response is back-pressured
        int            gap;    // idle cycles before the command is presented
        bit            early;  // presented while the previous response is still pending
    } cmd_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic [SW-1:0] cmd_sel_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [DW-1:0] rsp_dat_o;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o, wbm_dat_i;
    logic [SW-1:0] wbm_sel_o;
    logic [CW-1:0] xfer_cnt_o;

    wb_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
        .xfer_cnt_o(xfer_cnt_o)
    );

    always #5 clk = ~clk;

    int            cyc_n = 0;
    int            n_vec = 0;
    int            n_err = 0;
    bit            model_en = 1'b0;
    int            m_a = BIG, m_d = 0, m_er = BIG;
    int            m_done = 0;
    cmd_t          m_cmd;
    logic [DW-1:0] m_rdat;
    logic          m_err;
    logic [DW-1:0] mem [8];
    int            run_len = 0, last_run = 0;
    logic [DW-1:0] last_dat, last_wdat;
    logic          last_err;
    int            idle_from;
    bit            early_on = 1'b0;
    int            early_v;
    cmd_t          cmds [NTX];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    // Expected outputs after edge n follow from the transfer's timeline:
    // bus active on edges [a, a+d), response pending on [a+d, er).
    always @(posedge clk) begin : compare
        int n;
        bit bus, rsp;
        int exp_cnt;
        cyc_n = cyc_n + 1;
        #1;
        n = cyc_n;
        if (wbm_cyc_o) begin
            run_len++;
            last_wdat = wbm_dat_o;
        end else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (rsp_valid_o) begin
            last_dat = rsp_dat_o;
            last_err = rsp_err_o;
        end
        if (model_en) begin
            bus     = (n >= m_a) && (n < m_a + m_d);
            rsp     = (n >= m_a + m_d) && (n < m_er);
            exp_cnt = (n < m_a + m_d) ? m_done : m_done + 1;
            if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
            chk("cmd_ready", 64'(cmd_ready_o), 64'(!(n >= m_a && n < m_er)));
            chk("cyc", 64'(wbm_cyc_o), 64'(bus));
            chk("stb", 64'(wbm_stb_o), 64'(bus));
            chk("rsp_valid", 64'(rsp_valid_o), 64'(rsp));
            chk("xfer_cnt", 64'(xfer_cnt_o), 64'(exp_cnt));
            if (bus) begin
                chk("wbm_we", 64'(wbm_we_o), 64'(m_cmd.we));
                chk("wbm_adr", 64'(wbm_adr_o), 64'(m_cmd.adr));
                chk("wbm_dat", 64'(wbm_dat_o), 64'(m_cmd.dat));
                chk("wbm_sel", 64'(wbm_sel_o), 64'(m_cmd.sel));
            end
            if (rsp) begin
                chk("rsp_dat", 64'(rsp_dat_o), 64'(m_rdat));
                chk("rsp_err", 64'(rsp_err_o), 64'(m_err));
            end
        end
    end

    function automatic cmd_t rand_cmd();
        cmd_t c;
        int   r;
        c.we  = 1'($urandom_range(0, 1));
        c.adr = 32'h3000_0000 + 32'($urandom_range(0, 7) * 4);
        c.dat = $urandom;
        c.sel = SW'($urandom_range(0, (1 << SW) - 1));
        r = $urandom_range(0, 9);
        if (r < 5)      c.lat = $urandom_range(1, 4);
        else if (r < 7) c.lat = $urandom_range(TO - 1, TO);
        else if (r < 8) c.lat = $urandom_range(TO + 1, TO + 3);
        else            c.lat = $urandom_range(1, TO);
        c.rdly  = $urandom_range(0, 3);
        c.gap   = $urandom_range(0, 2);
        c.early = ($urandom_range(0, 2) == 0);
        return c;
    endfunction

    function automatic cmd_t mk(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                                input logic [SW-1:0] sel, input int lat, input int rdly, input bit early);
        cmd_t c;
        c.we = we; c.adr = adr; c.dat = dat; c.sel = sel;
        c.lat = lat; c.rdly = rdly; c.gap = 0; c.early = early;
        return c;
    endfunction

    task automatic drive_cmd(input cmd_t c);
        cmd_we_i    = c.we;
        cmd_adr_i   = c.adr;
        cmd_dat_i   = c.dat;
        cmd_sel_i   = c.sel;
        cmd_valid_i = 1'b1;
    endtask

    // Runs one transfer on a fixed timeline; all edges are known in advance.
    task automatic do_tx(input cmd_t c, input cmd_t nx);
        int v, a, d, er, e, idx;
        if (early_on) begin
            v = early_v;
        end else begin
            wbm_ack_i   = 1'b0;
            rsp_ready_i = 1'b0;
            repeat (c.gap) @(negedge clk);
            drive_cmd(c);
            v = cyc_n + 1;
        end
        early_on = 1'b0;
        a   = (v > idle_from) ? v : idle_from;
        d   = (c.lat <= TO) ? c.lat : TO;
        er  = a + d + 1 + c.rdly;
        idx = int'(c.adr[4:2]);
        m_cmd  = c;
        m_err  = (c.lat > TO);
        m_rdat = (!c.we && c.lat <= TO) ? mem[idx] : '0;
        m_a = a; m_d = d; m_er = er;
        do begin
            e = cyc_n + 1;
            if (e > a) begin
                if (nx.early && e > a + d) begin
                    if (!early_on) begin
                        early_on = 1'b1;
                        early_v  = e;
                        drive_cmd(nx);
                    end
                end else begin
                    cmd_valid_i = 1'b0;
                    cmd_we_i    = 1'($urandom_range(0, 1));
                    cmd_adr_i   = $urandom;
                    cmd_dat_i   = $urandom;
                end
            end
            if (c.lat <= TO && e == a + c.lat) begin
                wbm_ack_i = 1'b1;
                if (c.we) begin
                    wbm_dat_i = $urandom;
                    for (int b = 0; b < SW; b++)
                        if (c.sel[b]) mem[idx][8*b +: 8] = c.dat[8*b +: 8];
                end else begin
                    wbm_dat_i = mem[idx];
                end
            end else begin
                // stray acks outside the bus window must be ignored
                wbm_ack_i = (e <= a || e > a + d) ? ($urandom_range(0, 3) == 0) : 1'b0;
                wbm_dat_i = $urandom;
            end
            rsp_ready_i = (e == er) || (e <= a + d && $urandom_range(0, 1) == 1);
            @(negedge clk);
        end while (cyc_n < er);
        m_done++;
        m_a = BIG; m_d = 0; m_er = BIG;
        idle_from = er + 1;
    endtask

    initial begin : stim
        cmd_t nx;
        cmd_t c;
        reset = 1'b1;
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0; cmd_sel_i = '0;
        rsp_ready_i = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(0));
        chk("rst_cyc", 64'(wbm_cyc_o), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("rst_adr", 64'(wbm_adr_o), 64'(0));
        chk("rst_xfer_cnt", 64'(xfer_cnt_o), 64'(0));
        reset = 1'b0;
        idle_from = cyc_n + 1;
        model_en = 1'b1;

        cmds[0] = mk(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 2, 0, 1'b0);
        cmds[1] = mk(1'b0, 32'h3000_0000, 32'h0,         4'hF, 2, 0, 1'b0);
        cmds[2] = mk(1'b0, 32'h3000_0008, 32'h0,         4'hF, TO + 1, 1, 1'b0);
        cmds[3] = mk(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 1, 0, 1'b0);
        cmds[4] = mk(1'b0, 32'h3000_0004, 32'h0,         4'hF, TO, 0, 1'b0);
        cmds[5] = mk(1'b1, 32'h3000_000C, 32'hCAFE_F00D, 4'h3, 2, 5, 1'b0);
        cmds[6] = mk(1'b0, 32'h3000_000C, 32'h0,         4'hF, 3, 0, 1'b1);
        for (int i = 7; i < NTX; i++) cmds[i] = rand_cmd();

        for (int i = 0; i < NTX; i++) begin
            nx = (i + 1 < NTX) ? cmds[i + 1] : cmds[i];
            if (i + 1 >= NTX) nx.early = 1'b0;
            do_tx(cmds[i], nx);
            case (i)
                0: begin
                    chk("t0_bus_len", 64'(last_run), 64'(2));
                    chk("t0_wdat", 64'(last_wdat), 64'(32'hDEAD_BEEF));
                    chk("t0_rsp_dat", 64'(last_dat), 64'(0));
                    chk("t0_rsp_err", 64'(last_err), 64'(0));
                    chk("t0_xfer_cnt", 64'(xfer_cnt_o), 64'(1));
                end
                1: begin
                    chk("t1_rsp_dat", 64'(last_dat), 64'(32'hDEAD_BEEF));
                    chk("t1_rsp_err", 64'(last_err), 64'(0));
                    chk("t1_xfer_cnt", 64'(xfer_cnt_o), 64'(2));
                end
                2: begin
                    chk("t2_bus_len", 64'(last_run), 64'(TO));
                    chk("t2_rsp_err", 64'(last_err), 64'(1));
                    chk("t2_rsp_dat", 64'(last_dat), 64'(0));
                    chk("t2_xfer_cnt", 64'(xfer_cnt_o), 64'(3));
                end
                3: chk("t3_bus_len", 64'(last_run), 64'(1));
                4: begin
                    chk("t4_bus_len", 64'(last_run), 64'(TO));
                    chk("t4_rsp_err", 64'(last_err), 64'(0));
                    chk("t4_rsp_dat", 64'(last_dat), 64'(32'h1234_5678));
                end
                6: chk("t6_rsp_dat", 64'(last_dat), 64'(32'h0000_F00D));
                default: ;
            endcase
        end
        chk("cnt_saturated", 64'(xfer_cnt_o), 64'(CNT_MAX));

        // Reset during the second bus cycle of a transfer that would never be acked.
        model_en    = 1'b0;
        wbm_ack_i   = 1'b0;
        rsp_ready_i = 1'b0;
        c = mk(1'b1, 32'h3000_0010, 32'hA5A5_A5A5, 4'hF, TO + 1, 0, 1'b0);
        drive_cmd(c);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        chk("rstx_cyc_before", 64'(wbm_cyc_o), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstx_cyc", 64'(wbm_cyc_o), 64'(0));
        chk("rstx_stb", 64'(wbm_stb_o), 64'(0));
        chk("rstx_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("rstx_rsp_dat", 64'(rsp_dat_o), 64'(0));
        chk("rstx_rsp_err", 64'(rsp_err_o), 64'(0));
        chk("rstx_we", 64'(wbm_we_o), 64'(0));
        chk("rstx_adr", 64'(wbm_adr_o), 64'(0));
        chk("rstx_wdat", 64'(wbm_dat_o), 64'(0));
        chk("rstx_sel", 64'(wbm_sel_o), 64'(0));
        chk("rstx_xfer_cnt", 64'(xfer_cnt_o), 64'(0));
        chk("rstx_cmd_ready", 64'(cmd_ready_o), 64'(0));
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
            chk("post_rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
            chk("post_rst_cyc", 64'(wbm_cyc_o), 64'(0));
        end

        // Recovery: a few more model-checked transfers from a fresh count.
        m_done    = 0;
        early_on  = 1'b0;
        idle_from = cyc_n + 1;
        model_en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c  = rand_cmd();
            nx = c;
            nx.early = 1'b0;
            do_tx(c, nx);
        end
        model_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
